imem_fetch_ctrl: RTL and testbench

Fetch-side controller that sequences the slow 128-bit line instruction memory on behalf of the CPU fetch stage.
- Holds a single 16-byte line buffer and serves 32-bit words from it on hits.
- On a miss it drives a stable line address and waits out the fixed memory latency, then captures the line.
- It also handles redirect and flush mid-fill, and keeps hit/miss performance counters.

---
 rtl/imem_fetch_ctrl_pkg.sv | 19 +
 rtl/imem_fetch_ctrl_if.sv | 26 ++
 rtl/imem_fetch_ctrl_line_buf.sv | 45 ++++
 rtl/imem_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = 128;
    localparam int TAG_W      = 28;
    localparam int WORD_SEL_W = 2;

    function automatic logic [31:0] line_addr(input logic [31:0] pc);
        return {pc[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-stage and line-memory signals of the fetch controller.
// Handshake: the fetch stage raises fetch_req with fetch_pc and must hold both while stall is high; a request is accepted on an edge where stall is low.
interface imem_fetch_ctrl_if;
    import imem_ctrl_pkg::*;

    logic                 fetch_req;
    logic [31:0]          fetch_pc;
    logic                 flush;
    logic                 stall;
    logic [31:0]          instr;
    logic                 instr_valid;
    logic                 pc_misaligned;
    logic [31:0]          mem_addr;
    logic [LINE_BITS-1:0] mem_dataline;

    modport master (
        output fetch_req, fetch_pc, flush, mem_dataline,
        input  stall, instr, instr_valid, pc_misaligned, mem_addr
    );

    modport slave (
        input  fetch_req, fetch_pc, flush, mem_dataline,
        output stall, instr, instr_valid, pc_misaligned, mem_addr
    );

endinterface

// File: rtl/imem_fetch_ctrl_line_buf.sv
// Single-line buffer: tag, valid bit and 128-bit line with hit compare and word select.
module imem_line_buf
    import imem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic                 capture_i,
    input  logic [LINE_BITS-1:0] line_i,
    input  logic                 inval_i,
    input  logic [31:2]          pc_i,
    output logic                 hit_o,
    output logic [31:0]          word_o,
    output logic [TAG_W-1:0]     tag_o
);

    logic [TAG_W-1:0]     tag_q;
    logic                 valid_q;
    logic [LINE_BITS-1:0] line_q;
    logic [WORD_SEL_W-1:0] word_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            line_q  <= '0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            // A new tag always invalidates the old contents until its data lands.
            tag_q   <= tag_i;
            valid_q <= 1'b0;
        end else if (capture_i) begin
            line_q  <= line_i;
            valid_q <= 1'b1;
        end
    end

    assign word_sel = pc_i[3:2];
    assign hit_o    = valid_q && (tag_q == pc_i[31:4]);
    assign word_o   = line_q[{word_sel, 5'b00000} +: 32];
    assign tag_o    = tag_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: sequences line fills from the slow memory and serves words from the line buffer.
module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 7,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_fetch_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output state_t            dbg_state_o
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    // cnt_q counts edges since mem_addr changed, so the capture edge sees MEM_LATENCY.
    localparam logic [LAT_W-1:0] CAPTURE_AT = LAT_W'(MEM_LATENCY);

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                misal_q, misal_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic                buf_hit, hit;
    logic [31:0]         buf_word;
    logic [TAG_W-1:0]    buf_tag;
    logic                start_fill, capture;

    imem_line_buf u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (start_fill),
        .tag_i     (bus.fetch_pc[31:4]),
        .capture_i (capture),
        .line_i    (bus.mem_dataline),
        .inval_i   (bus.flush),
        .pc_i      (bus.fetch_pc[31:2]),
        .hit_o     (buf_hit),
        .word_o    (buf_word),
        .tag_o     (buf_tag)
    );

    assign hit = buf_hit && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            misal_q       <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misal_q       <= misal_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        misal_d       = misal_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        start_fill    = 1'b0;
        capture       = 1'b0;

        if (bus.flush) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    start_fill = bus.fetch_req;
                end
                READY: begin
                    if (bus.fetch_req && hit) begin
                        instr_d       = buf_word;
                        instr_valid_d = 1'b1;
                        misal_d       = (bus.fetch_pc[1:0] != 2'b00);
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        start_fill = bus.fetch_req;
                    end
                end
                FILL: begin
                    // A redirect wins over a capture landing on the same edge.
                    if (bus.fetch_req && (bus.fetch_pc[31:4] != buf_tag)) begin
                        start_fill = 1'b1;
                    end else if (cnt_q == CAPTURE_AT) begin
                        capture = 1'b1;
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LAT_W'(1);
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        if (start_fill) begin
            state_d    = FILL;
            cnt_d      = LAT_W'(1);
            mem_addr_d = line_addr(bus.fetch_pc);
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    assign bus.stall         = bus.fetch_req && !hit;
    assign bus.instr         = instr_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.pc_misaligned = misal_q;
    assign bus.mem_addr      = mem_addr_q;
    assign hit_count         = hit_cnt_q;
    assign miss_count        = miss_cnt_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a line-memory model and an abstract reference model.
module tb_imem_fetch_ctrl;
    import imem_ctrl_pkg::*;

    localparam int LAT   = 7;
    localparam int CW    = 2;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;
    state_t        dbg_state;

    imem_fetch_ctrl_if bus();

    imem_fetch_ctrl #(.MEM_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .dbg_state_o (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic last_stall;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Line memory: data for mem_addr is only correct once the address has been stable for 6 edges.
    logic [31:0] mem_prev = 32'h0;
    int          mem_stable = 0;
    always @(negedge clk) begin
        if (bus.mem_addr !== mem_prev) mem_stable = 0;
        else mem_stable++;
        mem_prev = bus.mem_addr;
        if (mem_stable >= LAT - 1)
            bus.mem_dataline = {word_of(bus.mem_addr + 32'd12), word_of(bus.mem_addr + 32'd8),
                                word_of(bus.mem_addr + 32'd4), word_of(bus.mem_addr)};
        else
            bus.mem_dataline = {4{32'hDEAD_BEEF}};
    end

    // Reference model: a fill lands LAT edges after its address is issued.
    logic        m_ok = 1'b0;
    logic        m_valid, m_filling, m_ivalid, m_mis;
    logic [27:0] m_tag;
    int          m_edges, m_hits, m_misses;
    logic [31:0] m_addr, m_instr;

    always @(negedge clk) begin
        logic m_hit;
        if (m_ok) begin
            chk("stall", 32'(bus.stall),
                32'(bus.fetch_req && !(m_valid && m_tag == bus.fetch_pc[31:4] && !bus.flush)));
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_ivalid));
            chk("instr", bus.instr, m_instr);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("hit_count", 32'(hit_count), 32'(m_hits));
            chk("miss_count", 32'(miss_count), 32'(m_misses));
            if (m_ivalid) chk("pc_misaligned", 32'(bus.pc_misaligned), 32'(m_mis));
        end
        m_hit = m_valid && m_tag == bus.fetch_pc[31:4] && !bus.flush;
        if (!rst_n) begin
            m_ok = 1'b1; m_valid = 1'b0; m_filling = 1'b0; m_ivalid = 1'b0; m_mis = 1'b0;
            m_tag = '0; m_edges = 0; m_hits = 0; m_misses = 0; m_addr = '0; m_instr = '0;
        end else if (m_ok) begin
            m_ivalid = 1'b0;
            if (bus.flush) begin
                m_valid = 1'b0;
                m_filling = 1'b0;
            end else if (bus.fetch_req && m_hit) begin
                m_instr  = word_of(bus.fetch_pc);
                m_ivalid = 1'b1;
                m_mis    = (bus.fetch_pc[1:0] != 2'b00);
                m_hits   = (m_hits < SAT) ? m_hits + 1 : SAT;
            end else if (bus.fetch_req && (!m_filling || bus.fetch_pc[31:4] != m_tag)) begin
                m_addr    = {bus.fetch_pc[31:4], 4'b0000};
                m_tag     = bus.fetch_pc[31:4];
                m_filling = 1'b1;
                m_edges   = 0;
                m_valid   = 1'b0;
                m_misses  = (m_misses < SAT) ? m_misses + 1 : SAT;
            end else if (m_filling) begin
                m_edges++;
                if (m_edges == LAT) begin
                    m_valid   = 1'b1;
                    m_filling = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic step(input logic req, input logic [31:0] pc, input logic fl);
        bus.fetch_req = req;
        bus.fetch_pc  = pc;
        bus.flush     = fl;
        #1;
        last_stall = bus.stall;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_serve(input logic [31:0] pc, output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, pc, 1'b0);
            if (!last_stall) return;
            n++;
        end
        chk("serve_timeout", 32'(n), 32'(LAT + 1));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_hits", 32'(hit_count), 32'h0);
        rst_n = 1'b1;

        // cold miss
        wait_serve(32'h40, n);
        chk("cold_stall_cycles", 32'(n), 32'd8);
        chk("cold_instr", bus.instr, 32'h5A5A_0040);
        chk("cold_valid", 32'(bus.instr_valid), 32'h1);
        chk("cold_mem_addr", bus.mem_addr, 32'h40);
        chk("cold_misses", 32'(miss_count), 32'd1);

        // sequential hits
        step(1'b1, 32'h44, 1'b0);
        chk("seq1_stall", 32'(last_stall), 32'h0);
        chk("seq1_instr", bus.instr, 32'h5A5A_0044);
        step(1'b1, 32'h48, 1'b0);
        chk("seq2_instr", bus.instr, 32'h5A5A_0048);
        step(1'b1, 32'h4C, 1'b0);
        chk("seq3_instr", bus.instr, 32'h5A5A_004C);
        chk("seq_hits_sat", 32'(hit_count), 32'd3);
        step(1'b0, 32'h4C, 1'b0);
        chk("idle_valid", 32'(bus.instr_valid), 32'h0);
        chk("idle_instr_hold", bus.instr, 32'h5A5A_004C);

        // misaligned
        step(1'b1, 32'h41, 1'b0);
        chk("mis_flag", 32'(bus.pc_misaligned), 32'h1);
        chk("mis_instr", bus.instr, 32'h5A5A_0040);
        step(1'b1, 32'h48, 1'b0);
        chk("aligned_flag", 32'(bus.pc_misaligned), 32'h0);

        // flush with request
        step(1'b1, 32'h44, 1'b1);
        chk("flush_stall", 32'(last_stall), 32'h1);
        chk("flush_valid", 32'(bus.instr_valid), 32'h0);
        chk("flush_no_fill", 32'(miss_count), 32'd1);
        wait_serve(32'h44, n);
        chk("refill_stall_cycles", 32'(n), 32'd8);
        chk("refill_instr", bus.instr, 32'h5A5A_0044);
        chk("refill_misses", 32'(miss_count), 32'd2);

        // redirect mid-fill
        repeat (3) step(1'b1, 32'h100, 1'b0);
        chk("pre_redirect_addr", bus.mem_addr, 32'h100);
        step(1'b1, 32'h80, 1'b0);
        chk("redirect_addr", bus.mem_addr, 32'h80);
        wait_serve(32'h80, n);
        chk("redirect_stall_cycles", 32'(n), 32'd7);
        chk("redirect_instr", bus.instr, 32'h5A5A_0080);
        wait_serve(32'h100, n);
        chk("old_line_not_captured", 32'(n), 32'd8);
        chk("miss_sat", 32'(miss_count), 32'd3);

        // reset mid-fill
        repeat (4) step(1'b1, 32'h200, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 32'h200, 1'b0);
        chk("midrst_mem_addr", bus.mem_addr, 32'h0);
        chk("midrst_instr", bus.instr, 32'h0);
        chk("midrst_hits", 32'(hit_count), 32'h0);
        chk("midrst_misses", 32'(miss_count), 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'(EMPTY));
        rst_n = 1'b1;
        repeat (10) step(1'b0, 32'h200, 1'b0);
        wait_serve(32'h200, n);
        chk("post_rst_no_capture", 32'(n), 32'd8);
        chk("post_rst_instr", bus.instr, 32'h5A5A_0200);

        // fill completes with request dropped
        step(1'b1, 32'h300, 1'b0);
        repeat (9) step(1'b0, 32'h300, 1'b0);
        wait_serve(32'h300, n);
        chk("bg_fill_stalls", 32'(n), 32'd0);
        chk("bg_fill_instr", bus.instr, 32'h5A5A_0300);
        chk("bg_fill_misses", 32'(miss_count), 32'd2);

        step(1'b0, 32'h0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
